// File: rtl/imem_arbiter.sv
// Round-robin arbiter and access sequencer sharing the instruction memory between CPU fetch and loader.
// Optional IMEM_ARB_LDR_LOCK_EN adds ldr_lock, giving the loader exclusive ownership while asserted.
module imem_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h00400000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  clear,
`ifdef IMEM_ARB_LDR_LOCK_EN
    input  logic                  ldr_lock,
`endif
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [31:0]           cpu_addr,
    output logic                  cpu_rsp_valid,
    output logic [31:0]           cpu_rsp_instr,
    output logic                  cpu_rsp_err,
    input  logic                  ldr_req_valid,
    output logic                  ldr_req_ready,
    input  logic [31:0]           ldr_addr,
    input  logic                  ldr_we,
    input  logic [31:0]           ldr_wdata,
    output logic                  ldr_rsp_valid,
    output logic [31:0]           ldr_rsp_rdata,
    output logic                  ldr_rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_index,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [31:0] SPAN = 32'(4) << DEPTH_LOG2;

    logic        lock;
    logic        last_ldr, last_ldr_nxt;
    logic        grant_cpu, grant_ldr, grant_any;
    logic [31:0] sel_addr, offset;
    logic        in_win;
    logic        rsp_cpu, rsp_ldr, rsp_err, rsp_rd;

`ifdef IMEM_ARB_LDR_LOCK_EN
    assign lock = ldr_lock;
`else
    assign lock = 1'b0;
`endif

    // State register: round-robin pointer plus the one-deep response pipeline.
    always_ff @(posedge clock) begin
        if (clear) begin
            last_ldr <= 1'b1;
            rsp_cpu  <= 1'b0;
            rsp_ldr  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_rd   <= 1'b0;
        end else begin
            last_ldr <= last_ldr_nxt;
            rsp_cpu  <= grant_cpu;
            rsp_ldr  <= grant_ldr;
            rsp_err  <= grant_any && !in_win;
            rsp_rd   <= grant_ldr && !ldr_we;
        end
    end

    // Grant and next-pointer; lock cycles leave the pointer untouched.
    always_comb begin
        grant_cpu    = 1'b0;
        grant_ldr    = 1'b0;
        last_ldr_nxt = last_ldr;
        if (!clear) begin
            if (lock) begin
                grant_ldr = ldr_req_valid;
            end else if (cpu_req_valid && ldr_req_valid) begin
                grant_cpu = last_ldr;
                grant_ldr = !last_ldr;
            end else begin
                grant_cpu = cpu_req_valid;
                grant_ldr = ldr_req_valid;
            end
            if ((grant_cpu || grant_ldr) && !lock)
                last_ldr_nxt = grant_ldr;
        end
    end

    assign grant_any = grant_cpu || grant_ldr;
    assign sel_addr  = grant_ldr ? ldr_addr : cpu_addr;
    assign offset    = sel_addr - BASE_ADDR;
    assign in_win    = (sel_addr >= BASE_ADDR) && (offset < SPAN) && (sel_addr[1:0] == 2'b00);

    // Outputs: memory issue in the handshake cycle, response strobes one cycle later.
    always_comb begin
        cpu_req_ready = grant_cpu;
        ldr_req_ready = grant_ldr;
        mem_en        = grant_any && in_win;
        mem_we        = grant_ldr && in_win && ldr_we;
        mem_index     = mem_en ? offset[DEPTH_LOG2+1:2] : '0;
        mem_wdata     = mem_we ? ldr_wdata : '0;

        cpu_rsp_valid = rsp_cpu && !clear;
        cpu_rsp_err   = cpu_rsp_valid && rsp_err;
        cpu_rsp_instr = (cpu_rsp_valid && !rsp_err) ? mem_rdata : '0;
        ldr_rsp_valid = rsp_ldr && !clear;
        ldr_rsp_err   = ldr_rsp_valid && rsp_err;
        ldr_rsp_rdata = (ldr_rsp_valid && !rsp_err && rsp_rd) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, hand sequences, then random traffic vs a transaction-level model.
module tb_imem_arbiter;

    localparam logic [31:0] BASE  = 32'h00400000;
    localparam int          WORDS = 256;

    logic        clock = 1'b0;
    logic        clear;
    logic        lock_in;
    logic        cpu_req_valid, cpu_req_ready, cpu_rsp_valid, cpu_rsp_err;
    logic [31:0] cpu_addr, cpu_rsp_instr;
    logic        ldr_req_valid, ldr_req_ready, ldr_we, ldr_rsp_valid, ldr_rsp_err;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rsp_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_index;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    imem_arbiter #(.BASE_ADDR(BASE), .DEPTH_LOG2(8)) dut (
        .clock(clock), .clear(clear),
`ifdef IMEM_ARB_LDR_LOCK_EN
        .ldr_lock(lock_in),
`endif
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_instr(cpu_rsp_instr), .cpu_rsp_err(cpu_rsp_err),
        .ldr_req_valid(ldr_req_valid), .ldr_req_ready(ldr_req_ready), .ldr_addr(ldr_addr),
        .ldr_we(ldr_we), .ldr_wdata(ldr_wdata),
        .ldr_rsp_valid(ldr_rsp_valid), .ldr_rsp_rdata(ldr_rsp_rdata), .ldr_rsp_err(ldr_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_index(mem_index), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Instruction memory array with registered read.
    logic [31:0] tmem [WORDS];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) tmem[mem_index] <= mem_wdata;
            else        mem_rdata <= tmem[mem_index];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: expected contents, who was served last, and the outstanding response.
    typedef struct {
        bit          c;
        bit          l;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } pend_t;

    logic [31:0] golden [WORDS];
    bit          served_ldr_last = 1'b1;
    pend_t       pend = '{0, 0, 0, 0, 32'h0};

    function automatic bit in_win(input logic [31:0] a);
        longint x = longint'(a);
        return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * WORDS) && (x % 4 == 0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4) % WORDS;
    endfunction

    task automatic cycle(input bit cv, input logic [31:0] ca, input bit lv, input logic [31:0] la,
                         input bit lwe, input logic [31:0] lwd, input bit clr, input bit lk,
                         output bit act_c, output bit act_l);
        bit gc, gl, ok;
        int idx;
        logic [31:0] addr;
        clear = clr; lock_in = lk;
        cpu_req_valid = cv; cpu_addr = ca;
        ldr_req_valid = lv; ldr_addr = la; ldr_we = lwe; ldr_wdata = lwd;
        gc = 0; gl = 0;
        if (!clr) begin
            if (lk)            gl = lv;
            else if (cv && lv) begin gc = served_ldr_last; gl = !served_ldr_last; end
            else               begin gc = cv; gl = lv; end
        end
        addr = gl ? la : ca;
        ok   = (gc || gl) && in_win(addr);
        idx  = word_of(addr);
        @(negedge clock);
        act_c = cpu_req_ready; act_l = ldr_req_ready;
        chk("cpu_req_ready", {31'b0, cpu_req_ready}, {31'b0, gc});
        chk("ldr_req_ready", {31'b0, ldr_req_ready}, {31'b0, gl});
        chk("mem_en", {31'b0, mem_en}, {31'b0, ok});
        chk("mem_we", {31'b0, mem_we}, {31'b0, ok && gl && lwe});
        if (ok) chk("mem_index", {24'b0, mem_index}, idx[31:0]);
        if (ok && gl && lwe) chk("mem_wdata", mem_wdata, lwd);
        chk("cpu_rsp_valid", {31'b0, cpu_rsp_valid}, {31'b0, pend.c && !clr});
        chk("cpu_rsp_err", {31'b0, cpu_rsp_err}, {31'b0, pend.c && !clr && pend.err});
        chk("cpu_rsp_instr", cpu_rsp_instr, (pend.c && !clr && !pend.err) ? pend.data : 32'h0);
        chk("ldr_rsp_valid", {31'b0, ldr_rsp_valid}, {31'b0, pend.l && !clr});
        chk("ldr_rsp_err", {31'b0, ldr_rsp_err}, {31'b0, pend.l && !clr && pend.err});
        chk("ldr_rsp_rdata", ldr_rsp_rdata,
            (pend.l && !clr && !pend.err && pend.rd) ? pend.data : 32'h0);
        @(posedge clock);
        if (clr) begin
            pend = '{0, 0, 0, 0, 32'h0};
            served_ldr_last = 1'b1;
        end else begin
            pend.c = gc; pend.l = gl;
            pend.err = (gc || gl) && !ok;
            pend.rd = gl && !lwe;
            pend.data = ok ? golden[idx] : 32'h0;
            if (ok && gl && lwe) golden[idx] = lwd;
            if ((gc || gl) && !lk) served_ldr_last = gl;
        end
        #1;
    endtask

    typedef struct {
        bit          cv;
        logic [31:0] ca;
        bit          lv;
        logic [31:0] la;
        bit          lwe;
        logic [31:0] lwd;
        bit          clr;
        bit          ec;
        bit          el;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        int w = $urandom_range(0, WORDS - 1);
        case (r)
            0:       return BASE + 32'(4 * WORDS);
            1:       return BASE - 32'd4;
            2:       return BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
            default: return BASE + 32'(w * 4);
        endcase
    endfunction

    initial begin
        bit ac, al;
        int lgrants, cstuck;
        for (int i = 0; i < WORDS; i++) begin tmem[i] = 32'h0; golden[i] = 32'h0; end
        lock_in = 1'b0;

        //          cv  ca            lv  la            we  wdata         clr ec el
        vecs.push_back('{1, 32'h00400000, 1, 32'h00400000, 1, 32'h20080005, 1, 0, 0});
        vecs.push_back('{1, 32'h00400000, 1, 32'h00400000, 1, 32'h20080005, 1, 0, 0});
        vecs.push_back('{1, 32'h00400010, 1, 32'h00400000, 1, 32'h20080005, 0, 1, 0});
        vecs.push_back('{0, 32'h0,        1, 32'h00400000, 1, 32'h20080005, 0, 0, 1});
        vecs.push_back('{0, 32'h0,        1, 32'h004003FC, 1, 32'h00000000, 0, 0, 1});
        vecs.push_back('{1, 32'h00400000, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 32'h0,        1, 32'h004003FC, 1, 32'hDEADBEEF, 0, 0, 1});
        vecs.push_back('{1, 32'h004003FC, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 32'h0,        1, 32'h00400000, 0, 32'h0,        0, 0, 1});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{1, 32'h00400000 + 32'(4 * i), 1, 32'h004003FC - 32'(4 * i), 0, 32'h0,
                             0, (i % 2) == 0, (i % 2) == 1});
        vecs.push_back('{1, 32'h00400400, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{1, 32'h003FFFFC, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{1, 32'h00400002, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 32'h0,        1, 32'h00400001, 1, 32'h12345678, 0, 0, 1});
        vecs.push_back('{1, 32'h004003FC, 0, 32'h0,        0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0});

        foreach (vecs[i]) begin
            cycle(vecs[i].cv, vecs[i].ca, vecs[i].lv, vecs[i].la, vecs[i].lwe, vecs[i].lwd,
                  vecs[i].clr, 1'b0, ac, al);
            chk($sformatf("vec%0d_cpu_grant", i), {31'b0, ac}, {31'b0, vecs[i].ec});
            chk($sformatf("vec%0d_ldr_grant", i), {31'b0, al}, {31'b0, vecs[i].el});
        end

        // Clear in the response cycle swallows the pending CPU response.
        cycle(1, 32'h00400000, 0, 32'h0, 0, 32'h0, 0, 0, ac, al);
        cycle(1, 32'h00400000, 0, 32'h0, 0, 32'h0, 1, 0, ac, al);
        chk("midreset_rsp_valid", {31'b0, cpu_rsp_valid}, 32'h0);
        cycle(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, ac, al);

`ifdef IMEM_ARB_LDR_LOCK_EN
        lgrants = 0; cstuck = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 32'h00400008, 1, 32'h00400000 + 32'(4 * i), 1, 32'hA0 + 32'(i), 0, 1, ac, al);
            lgrants += int'(al);
            cstuck  += int'(ac);
        end
        chk("lock_ldr_grants", 32'(lgrants), 32'd4);
        chk("lock_cpu_ready", 32'(cstuck), 32'd0);
        cycle(1, 32'h00400008, 1, 32'h00400000, 0, 32'h0, 0, 0, ac, al);
        chk("unlock_tie_cpu", {31'b0, ac}, 32'h1);
`else
        lgrants = 0; cstuck = 0;
`endif

        for (int i = 0; i < 500; i++) begin
            bit lk;
`ifdef IMEM_ARB_LDR_LOCK_EN
            lk = ($urandom_range(0, 3) == 0);
`else
            lk = 1'b0;
`endif
            cycle($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 1) == 1, rand_addr(),
                  $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 49) == 0, lk, ac, al);
        end
        cycle(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, ac, al);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
